// File: rtl/dram_line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dram_line_buffer : single-line write-back buffer, 32-bit Wishbone classic  |
// |                    slave to WORD_SIZE-bit DRAM line master. Rev 1.0         |
// +----------------------------------------------------------------------------+
module dram_line_buffer #(
   parameter int WORD_SIZE  = 128,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  user_clk_i,
   input  logic                  rst_n_i,
   input  logic                  cpu_cyc_i,
   input  logic                  cpu_stb_i,
   input  logic                  cpu_we_i,
   input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
   input  logic [3:0]            cpu_sel_i,
   input  logic [31:0]           cpu_data_i,
   output logic [31:0]           cpu_data_o,
   output logic                  cpu_ack_o,
   output logic                  mem_cyc_o,
   output logic                  mem_stb_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [WORD_SIZE-1:0]  mem_data_o,
   input  logic [WORD_SIZE-1:0]  mem_data_i,
   input  logic                  mem_ack_i,
   input  logic                  flush_i,
   output logic                  flush_done_o,
   output logic                  busy_o
);

   localparam int WPL    = WORD_SIZE / 32;
   localparam int OFS    = $clog2(WORD_SIZE / 8);
   localparam int TAG_W  = ADDR_WIDTH - OFS;
   localparam int BASE_W = $clog2(WORD_SIZE);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WB    = 3'd1,
      S_GAP_F = 3'd2,
      S_FILL  = 3'd3,
      S_FLUSH = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic                 valid_q, valid_d;
   logic                 dirty_q, dirty_d;
   logic [TAG_W-1:0]     tag_q, tag_d;
   logic [TAG_W-1:0]     req_tag_q, req_tag_d;
   logic [WORD_SIZE-1:0] line_q, line_d;
   logic                 ack_q, ack_d;
   logic [31:0]          rdata_q, rdata_d;
   logic                 mem_cyc_q, mem_cyc_d;
   logic                 mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [WORD_SIZE-1:0] mem_data_q, mem_data_d;
   logic                 flush_done_q, flush_done_d;
   logic                 busy_q, busy_d;

   logic                 w_req;
   logic                 w_hit;
   logic                 w_mem_ack;
   logic [TAG_W-1:0]     w_cpu_tag;
   logic [BASE_W-1:0]    w_base;
   logic                 w_addr_unused;

   assign w_cpu_tag     = cpu_addr_i[ADDR_WIDTH-1:OFS];
   assign w_addr_unused = ^cpu_addr_i[1:0];

   // Bit offset of the addressed 32-bit word inside the line.
   generate
      if (WPL > 1) begin : g_multi_word
         assign w_base = {cpu_addr_i[OFS-1:2], 5'b00000};
      end else begin : g_single_word
         assign w_base = '0;
      end
   endgenerate

   // The ack cycle masks the still-asserted strobe, so every access takes two cycles.
   assign w_req     = cpu_cyc_i & cpu_stb_i & ~ack_q;
   assign w_hit     = valid_q & (tag_q == w_cpu_tag);
   assign w_mem_ack = mem_ack_i & mem_cyc_q;

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      dirty_d      = dirty_q;
      tag_d        = tag_q;
      req_tag_d    = req_tag_q;
      line_d       = line_q;
      ack_d        = 1'b0;
      rdata_d      = rdata_q;
      flush_done_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (w_req) begin
               if (w_hit) begin
                  ack_d = 1'b1;
                  if (cpu_we_i) begin
                     dirty_d = 1'b1;
                     for (int b = 0; b < 4; b++) begin
                        if (cpu_sel_i[b]) begin
                           line_d[int'(w_base) + 8*b +: 8] = cpu_data_i[8*b +: 8];
                        end
                     end
                  end else begin
                     rdata_d = line_q[w_base +: 32];
                  end
               end else begin
                  req_tag_d = w_cpu_tag;
                  state_d   = (valid_q && dirty_q) ? S_WB : S_FILL;
               end
            end else if (flush_i) begin
               if (valid_q && dirty_q) begin
                  state_d = S_FLUSH;
               end else begin
                  flush_done_d = 1'b1;
               end
            end
         end
         S_WB: begin
            if (w_mem_ack) begin
               dirty_d = 1'b0;
               state_d = S_GAP_F;
            end
         end
         S_GAP_F: begin
            state_d = S_FILL;
         end
         S_FILL: begin
            if (w_mem_ack) begin
               line_d  = mem_data_i;
               tag_d   = req_tag_q;
               valid_d = 1'b1;
               dirty_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         S_FLUSH: begin
            if (w_mem_ack) begin
               dirty_d      = 1'b0;
               flush_done_d = 1'b1;
               state_d      = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Bus outputs are registered from the next state so they align with it.
   always_comb begin
      mem_cyc_d  = (state_d == S_WB) || (state_d == S_FILL) || (state_d == S_FLUSH);
      mem_we_d   = (state_d == S_WB) || (state_d == S_FLUSH);
      mem_addr_d = '0;
      mem_data_d = '0;
      if (state_d == S_FILL) begin
         mem_addr_d = {req_tag_d, {OFS{1'b0}}};
      end else if (mem_we_d) begin
         mem_addr_d = {tag_q, {OFS{1'b0}}};
         mem_data_d = line_q;
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge user_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= S_IDLE;
         valid_q      <= 1'b0;
         dirty_q      <= 1'b0;
         tag_q        <= '0;
         req_tag_q    <= '0;
         line_q       <= '0;
         ack_q        <= 1'b0;
         rdata_q      <= '0;
         mem_cyc_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         flush_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         dirty_q      <= dirty_d;
         tag_q        <= tag_d;
         req_tag_q    <= req_tag_d;
         line_q       <= line_d;
         ack_q        <= ack_d;
         rdata_q      <= rdata_d;
         mem_cyc_q    <= mem_cyc_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         flush_done_q <= flush_done_d;
         busy_q       <= busy_d;
      end
   end

   assign cpu_ack_o    = ack_q;
   assign cpu_data_o   = rdata_q;
   assign mem_cyc_o    = mem_cyc_q;
   assign mem_stb_o    = mem_cyc_q;
   assign mem_we_o     = mem_we_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_data_o   = mem_data_q;
   assign flush_done_o = flush_done_q;
   assign busy_o       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dram_line_buffer.sv
`default_nettype none
// Bench for dram_line_buffer: directed scenarios plus random CPU traffic checked
// against a flat word-memory model and a DRAM responder with a backing store.
module tb_dram_line_buffer;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cpu_cyc, cpu_stb, cpu_we;
   logic [31:0]   cpu_addr;
   logic [3:0]    cpu_sel;
   logic [31:0]   cpu_wdata;
   logic [31:0]   cpu_rdata;
   logic          cpu_ack;
   logic          mem_cyc, mem_stb, mem_we;
   logic [31:0]   mem_addr;
   logic [127:0]  mem_wdata;
   logic [127:0]  mem_rdata = '0;
   logic          mem_ack = 1'b0;
   logic          flush;
   logic          flush_done;
   logic          busy;

   dram_line_buffer #(.WORD_SIZE(128), .ADDR_WIDTH(32)) dut (
      .user_clk_i  (clk),
      .rst_n_i     (rst_n),
      .cpu_cyc_i   (cpu_cyc),
      .cpu_stb_i   (cpu_stb),
      .cpu_we_i    (cpu_we),
      .cpu_addr_i  (cpu_addr),
      .cpu_sel_i   (cpu_sel),
      .cpu_data_i  (cpu_wdata),
      .cpu_data_o  (cpu_rdata),
      .cpu_ack_o   (cpu_ack),
      .mem_cyc_o   (mem_cyc),
      .mem_stb_o   (mem_stb),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_data_o  (mem_wdata),
      .mem_data_i  (mem_rdata),
      .mem_ack_i   (mem_ack),
      .flush_i     (flush),
      .flush_done_o(flush_done),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   int unsigned cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: DRAM store, CPU-visible word memory, and the line the buffer should hold.
   logic [127:0] dram [logic [31:0]];
   logic [31:0]  gold [logic [31:0]];
   bit           m_valid = 0;
   bit           m_dirty = 0;
   logic [31:0]  m_tag   = '0;

   function automatic logic [127:0] dram_line(input logic [31:0] la);
      if (!dram.exists(la)) dram[la] = {$urandom(), $urandom(), $urandom(), $urandom()};
      return dram[la];
   endfunction

   function automatic logic [31:0] gold_word(input logic [31:0] wa);
      logic [127:0] l;
      if (gold.exists(wa)) return gold[wa];
      l = dram_line({wa[31:4], 4'h0});
      return l[32*wa[3:2] +: 32];
   endfunction

   function automatic logic [127:0] gold_line(input logic [31:0] la);
      logic [127:0] l;
      for (int w = 0; w < 4; w++) l[32*w +: 32] = gold_word(la + 32'(4*w));
      return l;
   endfunction

   typedef struct {
      bit           we;
      logic [31:0]  addr;
      logic [127:0] data;
      int unsigned  start_cyc;
      int unsigned  ack_cyc;
   } txn_t;
   txn_t txq[$];

   int          resp_wait  = 2;   // negative selects a random 0..3 wait
   int          stray_cnt  = 0;
   int          stray_done = 0;
   bit          in_txn     = 0;
   int          wait_left  = 0;
   logic [31:0] st_addr;
   logic [127:0] st_data;
   bit          st_we;
   int unsigned st_cyc;

   // DRAM controller responder.
   always @(negedge clk) begin
      if (!rst_n) begin
         in_txn  = 0;
         mem_ack = 1'b0;
      end else if (mem_ack) begin
         mem_ack = 1'b0;
         check_val("mem_cyc_drop", mem_cyc, 1'b0);
      end else if (mem_cyc) begin
         if (!in_txn) begin
            in_txn    = 1;
            wait_left = (resp_wait < 0) ? int'($urandom_range(0, 3)) : resp_wait;
            st_addr   = mem_addr;
            st_data   = mem_wdata;
            st_we     = mem_we;
            st_cyc    = cyc_cnt;
         end
         if (wait_left == 0) begin
            check_val("mem_stb", mem_stb, 1'b1);
            check_val("mem_hold_addr", mem_addr, st_addr);
            check_val("mem_hold_we", mem_we, st_we);
            check_val("mem_hold_data", mem_wdata, st_data);
            if (mem_we) dram[mem_addr] = mem_wdata;
            else        mem_rdata = dram_line(mem_addr);
            txq.push_back('{mem_we, mem_addr, mem_wdata, st_cyc, cyc_cnt});
            mem_ack = 1'b1;
            in_txn  = 0;
         end else begin
            wait_left--;
         end
      end else if (stray_cnt != stray_done) begin
         stray_done++;
         mem_ack = 1'b1;
      end
   end

   task automatic cpu_access(input bit we, input logic [31:0] addr, input logic [3:0] sel,
                             input logic [31:0] wdata, output logic [31:0] rdata);
      logic [31:0]  la, wa, exp_rd, old_tag, w;
      logic [127:0] wb_line;
      bit           hit, exp_wb, got;
      int           cycles, idx;
      int unsigned  ack_cyc;
      la      = {addr[31:4], 4'h0};
      wa      = {addr[31:2], 2'b00};
      hit     = m_valid && (m_tag == la);
      exp_wb  = !hit && m_valid && m_dirty;
      old_tag = m_tag;
      wb_line = exp_wb ? gold_line(m_tag) : '0;
      exp_rd  = gold_word(wa);
      txq.delete();
      cpu_cyc = 1; cpu_stb = 1; cpu_we = we; cpu_addr = addr; cpu_sel = sel; cpu_wdata = wdata;
      got = 0; cycles = 0;
      while (!got && cycles < 300) begin
         @(negedge clk);
         cycles++;
         got = cpu_ack;
      end
      check_val("ack_seen", got, 1'b1);
      rdata   = cpu_rdata;
      ack_cyc = cyc_cnt;
      cpu_cyc = 0; cpu_stb = 0; cpu_we = 0;
      check_val("busy_at_ack", busy, 1'b0);
      if (!hit) begin
         m_valid = 1; m_tag = la; m_dirty = 0;
      end
      if (we) begin
         w = exp_rd;
         for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = wdata[8*b +: 8];
         gold[wa] = w;
         m_dirty  = 1;
      end else begin
         check_val("rd_data", rdata, exp_rd);
      end
      check_val("n_txn", txq.size(), hit ? 0 : (exp_wb ? 2 : 1));
      if (hit) begin
         check_val("hit_lat", cycles, 1);
      end else if (txq.size() == (exp_wb ? 2 : 1)) begin
         idx = 0;
         if (exp_wb) begin
            check_val("wb_we", txq[0].we, 1'b1);
            check_val("wb_addr", txq[0].addr, old_tag);
            check_val("wb_data", txq[0].data, wb_line);
            check_val("wb_gap", txq[1].start_cyc - txq[0].ack_cyc, 2);
            idx = 1;
         end
         check_val("fill_we", txq[idx].we, 1'b0);
         check_val("fill_addr", txq[idx].addr, la);
         check_val("fill_lat", ack_cyc - txq[idx].ack_cyc, 2);
      end
      @(negedge clk);
      check_val("ack_once", cpu_ack, 1'b0);
   endtask

   task automatic do_flush();
      bit           exp_wb, got;
      logic [127:0] exp_line;
      logic [31:0]  exp_addr;
      int           cycles;
      exp_wb   = m_valid && m_dirty;
      exp_line = exp_wb ? gold_line(m_tag) : '0;
      exp_addr = m_tag;
      txq.delete();
      flush = 1;
      got = 0; cycles = 0;
      while (!got && cycles < 300) begin
         @(negedge clk);
         cycles++;
         got = flush_done;
      end
      flush = 0;
      check_val("flush_done", got, 1'b1);
      check_val("flush_n_txn", txq.size(), exp_wb ? 1 : 0);
      if (exp_wb && txq.size() == 1) begin
         check_val("flush_we", txq[0].we, 1'b1);
         check_val("flush_addr", txq[0].addr, exp_addr);
         check_val("flush_data", txq[0].data, exp_line);
      end
      if (!exp_wb) check_val("flush_clean_lat", cycles, 1);
      check_val("flush_busy", busy, 1'b0);
      m_dirty = 0;
      @(negedge clk);
      check_val("flush_pulse_once", flush_done, 1'b0);
   endtask

   logic [31:0] rd;
   logic [31:0] ra;
   int          acks, n;
   bit          seen;

   initial begin
      rst_n = 0; cpu_cyc = 0; cpu_stb = 0; cpu_we = 0; cpu_addr = '0;
      cpu_sel = '0; cpu_wdata = '0; flush = 0;
      repeat (3) @(negedge clk);
      check_val("rst_ack", cpu_ack, 1'b0);
      check_val("rst_rdata", cpu_rdata, 32'h0);
      check_val("rst_mem_cyc", mem_cyc, 1'b0);
      check_val("rst_mem_stb", mem_stb, 1'b0);
      check_val("rst_mem_we", mem_we, 1'b0);
      check_val("rst_mem_addr", mem_addr, 32'h0);
      check_val("rst_mem_data", mem_wdata, 128'h0);
      check_val("rst_flush_done", flush_done, 1'b0);
      check_val("rst_busy", busy, 1'b0);
      rst_n = 1;
      @(negedge clk);

      // Fill, hits, byte-merged write, then eviction with write-back.
      dram[32'h10] = 128'hAABBCCDD_EEFF0011_22334455_66778899;
      resp_wait = 2;
      cpu_access(0, 32'h10, 4'h0, 32'h0, rd);
      check_val("t1_rd", rd, 32'h66778899);
      check_val("t1_fill_addr", (txq.size() == 1) ? txq[0].addr : 32'hFFFF_FFFF, 32'h10);
      cpu_access(0, 32'h1C, 4'h0, 32'h0, rd);
      check_val("t2_rd", rd, 32'hAABBCCDD);
      cpu_access(1, 32'h14, 4'b0011, 32'hDEADBEEF, rd);
      cpu_access(0, 32'h14, 4'h0, 32'h0, rd);
      check_val("t3_rd", rd, 32'h2233BEEF);
      cpu_access(0, 32'h20, 4'h0, 32'h0, rd);
      check_val("t4_wb_data", (txq.size() == 2) ? txq[0].data : 128'h0,
                128'hAABBCCDD_EEFF0011_2233BEEF_66778899);
      check_val("t4_fill_addr", (txq.size() == 2) ? txq[1].addr : 32'hFFFF_FFFF, 32'h20);

      // Flush dirty line, then a flush with nothing to do; line stays valid.
      cpu_access(1, 32'h24, 4'hF, 32'hCAFEF00D, rd);
      do_flush();
      do_flush();
      cpu_access(0, 32'h24, 4'h0, 32'h0, rd);
      check_val("t5_rd", rd, 32'hCAFEF00D);

      // CPU abandons its cycle during FILL.
      txq.delete();
      acks = 0; seen = 0; n = 0;
      cpu_cyc = 1; cpu_stb = 1; cpu_we = 0; cpu_addr = 32'h40;
      while (!seen && n < 100) begin
         @(negedge clk);
         n++;
         if (cpu_ack) acks++;
         seen = mem_cyc && !mem_we;
      end
      cpu_cyc = 0; cpu_stb = 0;
      check_val("drop_fill_seen", seen, 1'b1);
      n = 0;
      while ((busy || mem_cyc) && n < 100) begin
         @(negedge clk);
         n++;
         if (cpu_ack) acks++;
      end
      repeat (2) begin
         @(negedge clk);
         if (cpu_ack) acks++;
      end
      check_val("drop_no_ack", acks, 0);
      check_val("drop_fill_txn", txq.size(), 1);
      m_valid = 1; m_tag = 32'h40; m_dirty = 0;
      cpu_access(0, 32'h44, 4'h0, 32'h0, rd);

      // Reset asserted while a write-back is pending.
      cpu_access(0, 32'h10, 4'h0, 32'h0, rd);
      cpu_access(1, 32'h18, 4'hF, 32'h12345678, rd);
      resp_wait = 1000;
      cpu_cyc = 1; cpu_stb = 1; cpu_we = 0; cpu_addr = 32'h50;
      seen = 0; n = 0;
      while (!seen && n < 50) begin
         @(negedge clk);
         n++;
         seen = mem_cyc && mem_we;
      end
      check_val("rst_wb_seen", seen, 1'b1);
      check_val("rst_wb_addr", mem_addr, 32'h10);
      #2 rst_n = 0;
      #1;
      check_val("rst_mid_cyc", mem_cyc, 1'b0);
      check_val("rst_mid_busy", busy, 1'b0);
      cpu_cyc = 0; cpu_stb = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      resp_wait = 2;
      m_valid = 0; m_dirty = 0;
      gold.delete();
      @(negedge clk);
      cpu_access(0, 32'h18, 4'h0, 32'h0, rd);
      check_val("t6_rd", rd, 32'hEEFF0011);
      check_val("t6_fill_only", txq.size(), 1);

      // An ack with no DRAM cycle open must be ignored.
      stray_cnt++;
      repeat (3) @(negedge clk);
      check_val("stray_busy", busy, 1'b0);
      check_val("stray_cyc", mem_cyc, 1'b0);
      check_val("stray_ack", cpu_ack, 1'b0);
      cpu_access(0, 32'h1C, 4'h0, 32'h0, rd);

      // Random traffic over three lines with occasional flushes.
      resp_wait = -1;
      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            do_flush();
         end else begin
            ra = 32'h100 + 32'($urandom_range(0, 2) << 4) + 32'($urandom_range(0, 15));
            cpu_access(bit'($urandom_range(0, 1)), ra, 4'($urandom()), $urandom(), rd);
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
